mc_control_fsm: RTL

- Multi-cycle control sequencer for the RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALUOp class consumed by the ALU control unit, plus all mux selects and write strobes of the shared-ALU datapath.
- Handles variable-latency memory through a ready handshake.

---
 rtl/mc_control_fsm_pkg.sv | 56 +++++
 rtl/mc_control_fsm_if.sv | 40 ++++
 rtl/mc_ctrl_next_state.sv | 63 ++++++
 rtl/mc_control_fsm.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// rtl/mc_control_fsm_pkg.sv - shared encodings for the multi-cycle control sequencer
// Purpose: state encodings (4-bit), RV32I opcodes, ALUOp classes and datapath
//          mux-select encodings shared by the sequencer, its next-state logic
//          and anything decoding the control bus.
// Ports:   none (package).
package mc_control_fsm_pkg;

  localparam int OPC_W = 7;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EX    = 4'd2,
    S_WB    = 4'd3,
    S_MADDR = 4'd4,
    S_MRD   = 4'd5,
    S_MWB   = 4'd6,
    S_MWR   = 4'd7,
    S_BR    = 4'd8,
    S_BTGT  = 4'd9,
    S_JAL   = 4'd10,
    S_JALR  = 4'd11,
    S_ECALL = 4'd12,
    S_HALT  = 4'd13
  } state_e;

  localparam logic [OPC_W-1:0] OPC_ARITH     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_ARITH_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM    = 7'b1110011;

  // ALUOp classes consumed by the ALU control unit
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_ARITH  = 2'b01;
  localparam logic [1:0] ALUOP_BRANCH = 2'b10;

  // Register-file write-back source
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // ALU operand A source
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_REG    = 2'b01;
  localparam logic [1:0] SRCA_OLD_PC = 2'b10;

  // ALU operand B source
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control bus between the sequencer and the shared-ALU datapath
// Purpose: groups the datapath status inputs (opcode, alu_bcond, ecall_halt,
//          mem_ready) and every control strobe/select the sequencer drives.
// Modports: master = sequencer side, slave = datapath side.
interface mc_control_fsm_if #(
  parameter int OPCODE_W = 7
);

  logic [OPCODE_W-1:0] opcode;
  logic                alu_bcond;
  logic                ecall_halt;
  logic                mem_ready;

  logic       pc_write;
  logic       pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_ecall;
  logic       halted;

  modport master (
    input  opcode, alu_bcond, ecall_halt, mem_ready,
    output pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_ecall, halted
  );

  modport slave (
    output opcode, alu_bcond, ecall_halt, mem_ready,
    input  pc_write, pc_src, i_or_d, mem_read, mem_write, ir_write,
           reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_ecall, halted
  );

endinterface

// File: rtl/mc_ctrl_next_state.sv
// rtl/mc_ctrl_next_state.sv - combinational next-state function of the control sequencer
// Purpose: computes the next sequencer state from the current state, the IR
//          opcode and the datapath status bits.
// Ports:   state_q (current state), opcode, alu_bcond, mem_ready, ecall_halt
//          in; state_d (next state) out.
module mc_ctrl_next_state
  import mc_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = OPC_W
) (
  input  state_e              state_q,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_bcond,
  input  logic                mem_ready,
  input  logic                ecall_halt,
  output state_e              state_d
);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (mem_ready) state_d = S_ID;
      end
      S_ID: begin
        if (opcode == OPC_ARITH || opcode == OPC_ARITH_IMM) begin
          state_d = S_EX;
        end else if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
          state_d = S_MADDR;
        end else if (opcode == OPC_BRANCH) begin
          state_d = S_BR;
        end else if (opcode == OPC_JAL) begin
          state_d = S_JAL;
        end else if (opcode == OPC_JALR) begin
          state_d = S_JALR;
        end else if (opcode == OPC_SYSTEM) begin
          state_d = S_ECALL;
        end else begin
          // Unrecognised opcodes retire as a NOP; PC was already advanced in ID
          state_d = S_IF;
        end
      end
      S_EX:    state_d = S_WB;
      S_WB:    state_d = S_IF;
      S_MADDR: state_d = (opcode == OPC_STORE) ? S_MWR : S_MRD;
      S_MRD: begin
        if (mem_ready) state_d = S_MWB;
      end
      S_MWB:   state_d = S_IF;
      S_MWR: begin
        if (mem_ready) state_d = S_IF;
      end
      S_BR:    state_d = alu_bcond ? S_BTGT : S_IF;
      S_BTGT:  state_d = S_IF;
      S_JAL:   state_d = S_IF;
      S_JALR:  state_d = S_IF;
      S_ECALL: state_d = ecall_halt ? S_HALT : S_IF;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle control sequencer for the RV32I core
// Purpose: steps each instruction through fetch/decode/execute/memory/writeback,
//          holds the state register and decodes all datapath strobes, mux
//          selects and the 2-bit ALUOp class. Memory states wait on mem_ready.
// Ports:   clk, reset_n (async active-low); bus (mc_control_fsm_if.master):
//          opcode/alu_bcond/ecall_halt/mem_ready in, control strobes out.
//          With MC_CTRL_PERF_CNT_EN defined: cycle_cnt and instret_cnt outputs.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int OPCODE_W = OPC_W
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mc_control_fsm_if.master     bus
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
`endif
);

  state_e state_q;
  state_e state_d;

  logic [OPCODE_W-1:0] opcode;
  assign opcode = bus.opcode;

  mc_ctrl_next_state #(
    .OPCODE_W (OPCODE_W)
  ) u_next_state (
    .state_q    (state_q),
    .opcode     (opcode),
    .alu_bcond  (bus.alu_bcond),
    .mem_ready  (bus.mem_ready),
    .ecall_halt (bus.ecall_halt),
    .state_d    (state_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  logic       pc_write;
  logic       pc_src;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_ecall;
  logic       halted;

  // Outputs are gated by reset_n so that no strobe can stay high while reset
  // is held, even though the state register already sits at S_IF.
  always_comb begin
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALUOUT;
    alu_src_a = SRCA_PC;
    alu_src_b = SRCB_REG;
    alu_op    = ALUOP_ADD;
    is_ecall  = 1'b0;
    halted    = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = bus.mem_ready;
        end
        S_ID: begin
          // PC <= PC + 4 while the IR decodes
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALUOP_ADD;
          pc_write  = 1'b1;
        end
        S_EX: begin
          alu_src_a = SRCA_REG;
          alu_src_b = (opcode == OPC_ARITH) ? SRCB_REG : SRCB_IMM;
          alu_op    = ALUOP_ARITH;
        end
        S_WB: begin
          reg_write = 1'b1;
          wb_sel    = WB_ALUOUT;
        end
        S_MADDR: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
        end
        S_MRD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MWB: begin
          reg_write = 1'b1;
          wb_sel    = WB_MDR;
        end
        S_MWR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
        end
        S_BR: begin
          alu_src_a = SRCA_REG;
          alu_src_b = SRCB_REG;
          alu_op    = ALUOP_BRANCH;
        end
        S_BTGT: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          pc_write  = 1'b1;
        end
        S_JAL, S_JALR: begin
          // Link and jump in one cycle: the RF captures PC (old_pc+4) before
          // the PC register takes the ALU target on the same edge.
          reg_write = 1'b1;
          wb_sel    = WB_PC;
          alu_src_a = (state_q == S_JAL) ? SRCA_OLD_PC : SRCA_REG;
          alu_src_b = SRCB_IMM;
          alu_op    = ALUOP_ADD;
          pc_write  = 1'b1;
        end
        S_ECALL: begin
          is_ecall = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write  = pc_write;
  assign bus.pc_src    = pc_src;
  assign bus.i_or_d    = i_or_d;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.ir_write  = ir_write;
  assign bus.reg_write = reg_write;
  assign bus.wb_sel    = wb_sel;
  assign bus.alu_src_a = alu_src_a;
  assign bus.alu_src_b = alu_src_b;
  assign bus.alu_op    = alu_op;
  assign bus.is_ecall  = is_ecall;
  assign bus.halted    = halted;

`ifdef MC_CTRL_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q;
  logic [CNT_W-1:0] instret_cnt_d;

  // An instruction retires whenever the sequencer returns to fetch, plus the
  // halting ECALL which never returns to fetch.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if (state_q != S_HALT) begin
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    end
    if ((state_d == S_IF && state_q != S_IF) ||
        (state_q == S_ECALL && state_d == S_HALT)) begin
      instret_cnt_d = instret_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
